// File: rtl/pixel_weight_loader.sv
// pixel_weight_loader
// Byte-serial loader for the binarized 28x28 image and the 3x3x8 first-layer
// binary weights. Bytes arrive over a valid/ready handshake while the
// top-level state is s_LOAD and are packed LSB first into pixels[] and then
// weights[]. load_done is held until the top level returns to s_IDLE.
//
// Optional feature: define LOADER_CHECKSUM_EN to expect one extra byte after
// the weights. That byte is compared against the running XOR of all data
// bytes, and load_err reports a mismatch. Without the macro load_err is
// tied low.

module pixel_weight_loader #(
  parameter int N_PIX_BYTES = 98,
  parameter int N_WGT_BYTES = 9
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [2:0]                 state,
  input  logic [7:0]                 data_in,
  input  logic                       data_valid,
  output logic                       data_ready,
  output logic [8*N_PIX_BYTES-1:0]   pixels,
  output logic [8*N_WGT_BYTES-1:0]   weights,
  output logic                       load_done,
  output logic                       load_err
);

  localparam logic [2:0] S_IDLE = 3'b000;
  localparam logic [2:0] S_LOAD = 3'b001;

  localparam int PIX_AW = $clog2(8 * N_PIX_BYTES);
  localparam int WGT_AW = $clog2(8 * N_WGT_BYTES);

  // Index of the last pixel byte and of the last weight byte in the frame.
  localparam logic [6:0] C_PIX_BYTES = 7'(N_PIX_BYTES);
  localparam logic [6:0] C_LAST_PIX  = 7'(N_PIX_BYTES - 1);
  localparam logic [6:0] C_LAST_WGT  = 7'(N_PIX_BYTES + N_WGT_BYTES - 1);

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    L_IDLE = 3'd0,
    L_PIX  = 3'd1,
    L_WGT  = 3'd2,
    L_CHK  = 3'd3,
    L_DONE = 3'd4
  } lstate_t;
`else
  typedef enum logic [2:0] {
    L_IDLE = 3'd0,
    L_PIX  = 3'd1,
    L_WGT  = 3'd2,
    L_DONE = 3'd4
  } lstate_t;
`endif

  lstate_t                   r_lstate;
  lstate_t                   w_lstate_next;
  logic [6:0]                r_cnt;
  logic [8*N_PIX_BYTES-1:0]  r_pixels;
  logic [8*N_WGT_BYTES-1:0]  r_weights;

  logic                      w_in_load;
  logic                      w_ready;
  logic                      w_accept;
  logic                      w_start;
  logic [PIX_AW-1:0]         w_pix_base;
  logic [WGT_AW-1:0]         w_wgt_base;

  assign w_in_load = (state == S_LOAD);

  // Ready depends on the registered loader state, so it first rises one
  // cycle after the top level enters s_LOAD. It also drops as soon as the
  // top level leaves s_LOAD, so a byte is never taken during an abort.
  always_comb begin
    w_ready = 1'b0;
    if (w_in_load) begin
      case (r_lstate)
        L_PIX, L_WGT: w_ready = 1'b1;
`ifdef LOADER_CHECKSUM_EN
        L_CHK:        w_ready = 1'b1;
`endif
        default:      w_ready = 1'b0;
      endcase
    end
  end

  assign w_accept = data_valid && w_ready;
  assign w_start  = (r_lstate == L_IDLE) && w_in_load;

  // Byte k lands at bit 8k of pixels. Weight byte k lands at bit 8(k-98) of
  // weights. Both bases are byte counts scaled by eight.
  assign w_pix_base = PIX_AW'({r_cnt, 3'b000});
  assign w_wgt_base = WGT_AW'({r_cnt - C_PIX_BYTES, 3'b000});

  // Next-state logic. Leaving s_LOAD mid-frame abandons the frame. The final
  // accept completes even if state changes on that same edge, because it is
  // qualified by the state sampled at that edge.
  always_comb begin
    // NOTE: assign a default before the case so every path drives the
    // variable; a path that leaves it unassigned would infer a latch.
    w_lstate_next = r_lstate;
    case (r_lstate)
      L_IDLE: if (w_in_load) w_lstate_next = L_PIX;
      L_PIX: begin
        if (!w_in_load)                             w_lstate_next = L_IDLE;
        else if (w_accept && r_cnt == C_LAST_PIX)   w_lstate_next = L_WGT;
      end
      L_WGT: begin
        if (!w_in_load) begin
          w_lstate_next = L_IDLE;
        end else if (w_accept && r_cnt == C_LAST_WGT) begin
`ifdef LOADER_CHECKSUM_EN
          w_lstate_next = L_CHK;
`else
          w_lstate_next = L_DONE;
`endif
        end
      end
`ifdef LOADER_CHECKSUM_EN
      L_CHK: begin
        if (!w_in_load)    w_lstate_next = L_IDLE;
        else if (w_accept) w_lstate_next = L_DONE;
      end
`endif
      L_DONE: if (state == S_IDLE) w_lstate_next = L_IDLE;
      default: w_lstate_next = L_IDLE;
    endcase
  end

  // Loader state register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so that every
    // flop samples values from before the edge, whatever the block order.
    if (!rst_n) r_lstate <= L_IDLE;
    else        r_lstate <= w_lstate_next;
  end

  // Byte counter. It restarts at 0 on every new load, including after an
  // abort, and advances by one per accepted byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_cnt <= '0;
    else if (w_start)  r_cnt <= '0;
    else if (w_accept) r_cnt <= r_cnt + 7'd1;
  end

  // Image buffer. Only the addressed byte changes on an accept. Contents
  // survive aborts and the return to idle.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: these buffers are ordinary flops, not a RAM. The consumer
    // depends on them reading 0 after reset, so they take the async reset.
    if (!rst_n)
      r_pixels <= '0;
    else if (w_accept && r_lstate == L_PIX)
      r_pixels[w_pix_base +: 8] <= data_in;
  end

  // Weight buffer. It is written the same way as the image buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_weights <= '0;
    else if (w_accept && r_lstate == L_WGT)
      r_weights[w_wgt_base +: 8] <= data_in;
  end

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] r_xor;
  logic       r_err;

  // Running XOR of the pixel and weight bytes of the current frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_xor <= '0;
    else if (w_start)
      r_xor <= '0;
    else if (w_accept && (r_lstate == L_PIX || r_lstate == L_WGT))
      r_xor <= r_xor ^ data_in;
  end

  // Checksum verdict. It is latched on the check-byte accept and cleared
  // when the completed frame is released.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_err <= 1'b0;
    else if (w_accept && r_lstate == L_CHK)
      r_err <= (data_in != r_xor);
    else if (r_lstate == L_DONE && state == S_IDLE)
      r_err <= 1'b0;
  end

  assign load_err = r_err;
`else
  assign load_err = 1'b0;
`endif

  assign data_ready = w_ready;
  assign load_done  = (r_lstate == L_DONE);
  assign pixels     = r_pixels;
  assign weights    = r_weights;

endmodule
